inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of entries; power of two, at least 4.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port flush, input, 1 bit: discard all queued entries (branch redirect or exception).
REQ-005 SHALL have port in_valid_1, input, 1 bit: first fetched instruction valid; driven from the cache i_ready_1.
REQ-006 SHALL have port in_valid_2, input, 1 bit: second fetched instruction valid; driven from the cache i_ready_2.
REQ-007 SHALL have port in_pc, input, 32 bits: PC of the first fetched instruction.
REQ-008 SHALL have ports in_inst_1 and in_inst_2, input, 32 bits each: fetched instruction words.
REQ-009 SHALL have port in_stall, output, 1 bit: the queue cannot accept a 2-instruction push.
REQ-010 SHALL have ports out_valid_1 and out_valid_2, output, 1 bit each: head and head+1 entries valid.
REQ-011 SHALL have ports out_pc_1, out_inst_1, out_pc_2 and out_inst_2, output, 32 bits each: PC and instruction of the head and head+1 entries.
REQ-012 SHALL have ports out_ready_1 and out_ready_2, input, 1 bit each: decode consumes the head entry and the head+1 entry.
REQ-013 SHALL have port count, output, log2(DEPTH)+1 bits: occupied entries.

Function
REQ-014 SHALL store each entry as {pc[31:0], inst[31:0]} in a circular buffer indexed by wptr and rptr, each log2(DEPTH) bits and wrapping modulo DEPTH.
REQ-015 SHALL compute push_n from in_valid_1 and in_valid_2: in_valid_1=0 gives push_n=0; in_valid_1=1, in_valid_2=0 gives push_n=1; both set gives push_n=2.
REQ-016 SHALL ignore in_valid_2 when in_valid_1=0.
REQ-017 SHALL force push_n=0 when in_stall=1 or flush=1; offered instructions are then dropped and the upstream SHALL hold or refetch them.
REQ-018 SHALL write entry wptr with {in_pc, in_inst_1} and, when push_n=2, entry wptr+1 with {in_pc+4, in_inst_2}, modulo 2^32.
REQ-019 SHALL advance wptr by push_n.
REQ-020 SHALL drive in_stall = (count > DEPTH-2), computed from registered count only, with no combinational path from out_ready.
REQ-021 SHALL drive out_valid_1 = (count >= 1) and out_valid_2 = (count >= 2).
REQ-022 SHALL drive out_* combinationally from entries rptr and rptr+1; the data fields are don't-care when the matching valid is 0.
REQ-023 SHALL compute pop_n: out_ready_1 && out_valid_1 gives 1; that AND out_ready_2 && out_valid_2 gives 2; otherwise 0.
REQ-024 SHALL ignore out_ready_2 when out_ready_1=0.
REQ-025 SHALL advance rptr by pop_n.
REQ-026 SHALL update count to count + push_n - pop_n, with simultaneous push and pop in the same cycle legal.
REQ-027 SHALL make a pushed entry visible on out_* in the cycle after the push, with no same-cycle bypass to the outputs.
REQ-028 SHALL give flush priority over push and pop: on flush=1 the next-cycle state is wptr=rptr=0 and count=0.
REQ-029 SHALL leave entry contents unchanged on flush.
REQ-030 SHALL not let count exceed DEPTH or go below 0 under any input combination.
REQ-031 SHALL continue the wrap-around write correctly when wptr=DEPTH-1 and push_n=2, writing the second instruction to entry 0.

Reset
REQ-032 SHALL, while resetn=0 at a rising clk edge, set wptr=0, rptr=0 and count=0.
REQ-033 SHALL drive out_valid_1=0, out_valid_2=0 and in_stall=0 from the cycle after reset.
REQ-034 SHALL discard an in-progress push or pop coincident with reset.
REQ-035 SHALL NOT require entry storage to be reset.

Verification
REQ-036 SHALL cover dual push then pop: after reset, push pc=0x1000, insts A and B, with out_ready low -> next cycle count=2, out_pc_1=0x1000, out_pc_2=0x1004, out_inst_1=A and out_inst_2=B; then both readies high -> count=0.
REQ-037 SHALL cover fill: with DEPTH=8, three dual pushes and no pops -> count=6, in_stall=0; one more dual push -> count=8, in_stall=1; a further offered push -> dropped, count stays 8.
REQ-038 SHALL cover simultaneous events: count=3, push_n=2 and pop_n=1 in the same cycle -> count=4, and the head advances to the former second entry.
REQ-039 SHALL cover wrap-around: wptr=7, push pc=0x2000 -> entry 7 holds pc 0x2000 and entry 0 holds pc 0x2004; the out_* order is preserved across the wrap.
REQ-040 SHALL cover flush with a push: count=5, flush=1 with in_valid_1=1 -> next cycle count=0, out_valid_1=0; the pushed instruction never appears on out_*.
REQ-041 SHALL cover reset mid-operation: count=4, resetn=0 for one cycle -> count=0, out_valid_1=0 and in_stall=0; a subsequent push behaves exactly as in REQ-036.

Source files
------------

// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
//   Instruction queue between the fetch stage and decode. Fetch may push up to
//   two sequential instructions per cycle (PC and PC+4). Decode may consume up
//   to two instructions per cycle from the head. Entries are kept in a circular
//   buffer of {pc, inst} words addressed by write/read pointers that wrap
//   modulo DEPTH.
//
// Ports
//   clk          : clock; all state updates on its rising edge
//   resetn       : synchronous active-low reset (pointers and count only)
//   flush        : discard all queued entries (redirect/exception)
//   in_valid_1   : first fetched instruction valid
//   in_valid_2   : second fetched instruction valid (ignored without valid_1)
//   in_pc        : PC of the first fetched instruction
//   in_inst_1/2  : fetched instruction words
//   in_stall     : queue cannot take a two-instruction push this cycle
//   out_valid_1/2: head / head+1 entries valid
//   out_pc_1/2   : PC of head / head+1 entries
//   out_inst_1/2 : instruction of head / head+1 entries
//   out_ready_1/2: decode consumes head / head+1 (ready_2 ignored without 1)
//   count        : number of occupied entries
// -----------------------------------------------------------------------------
module inst_queue #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       in_valid_1,
    input  logic                       in_valid_2,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_inst_1,
    input  logic [31:0]                in_inst_2,
    output logic                       in_stall,
    output logic                       out_valid_1,
    output logic                       out_valid_2,
    output logic [31:0]                out_pc_1,
    output logic [31:0]                out_inst_1,
    output logic [31:0]                out_pc_2,
    output logic [31:0]                out_inst_2,
    input  logic                       out_ready_1,
    input  logic                       out_ready_2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_STALL_TH = (AW+1)'(DEPTH - 2);
    localparam logic [AW:0] C_ONE      = (AW+1)'(1);
    localparam logic [AW:0] C_TWO      = (AW+1)'(2);

    // Entry storage: {pc, inst}. Deliberately not reset.
    logic [63:0]   r_mem [DEPTH];

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic [AW-1:0] w_wptr_p1;
    logic [AW-1:0] w_rptr_p1;
    logic          w_push_ok;
    logic [1:0]    w_push_n;
    logic [1:0]    w_pop_n;
    logic          w_pop_1;
    logic          w_pop_2;
    logic [31:0]   w_pc_p4;

    assign w_wptr_p1 = r_wptr + AW'(1);
    assign w_rptr_p1 = r_rptr + AW'(1);
    assign w_pc_p4   = in_pc + 32'd4;

    // Stall depends on the registered count only, so there is no combinational
    // path from out_ready back to the fetch side. A stall also blocks single
    // pushes: with DEPTH-1 entries a single push would fit, but the upstream
    // cannot know how many of its two slots we would take.
    assign in_stall    = (r_count > C_STALL_TH);
    assign out_valid_1 = (r_count >= C_ONE);
    assign out_valid_2 = (r_count >= C_TWO);

    // Push: flush and stall drop the offered instructions; reset does as well
    // so the (unreset) storage is not written by a push that is being thrown
    // away anyway.
    assign w_push_ok = resetn && !flush && !in_stall && in_valid_1;
    assign w_push_n  = !w_push_ok ? 2'd0 : (in_valid_2 ? 2'd2 : 2'd1);

    // Pop: second slot only counts if the first is consumed too.
    assign w_pop_1 = out_ready_1 && out_valid_1;
    assign w_pop_2 = w_pop_1 && out_ready_2 && out_valid_2;
    assign w_pop_n = w_pop_2 ? 2'd2 : (w_pop_1 ? 2'd1 : 2'd0);

    // Read side is purely combinational from the head pointer; newly pushed
    // entries become visible only after the count register updates.
    assign out_pc_1   = r_mem[r_rptr][63:32];
    assign out_inst_1 = r_mem[r_rptr][31:0];
    assign out_pc_2   = r_mem[w_rptr_p1][63:32];
    assign out_inst_2 = r_mem[w_rptr_p1][31:0];

    assign count = r_count;

    // Storage write; the second instruction wraps to entry 0 naturally via
    // the modulo-DEPTH pointer increment.
    always_ff @(posedge clk) begin
        if (w_push_n != 2'd0) begin
            r_mem[r_wptr] <= {in_pc, in_inst_1};
        end
        if (w_push_n == 2'd2) begin
            r_mem[w_wptr_p1] <= {w_pc_p4, in_inst_2};
        end
    end

    // Pointers and occupancy. Flush wins over push and pop but leaves the
    // storage contents alone.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_push_n);
            r_rptr  <= r_rptr + AW'(w_pop_n);
            r_count <= r_count + (AW+1)'(w_push_n) - (AW+1)'(w_pop_n);
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed scenarios with literal expectations, then
// randomized traffic, all checked against a queue-based reference model.
module tb_inst_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        in_valid_1, in_valid_2;
    logic [31:0] in_pc, in_inst_1, in_inst_2;
    logic        in_stall;
    logic        out_valid_1, out_valid_2;
    logic [31:0] out_pc_1, out_inst_1, out_pc_2, out_inst_2;
    logic        out_ready_1, out_ready_2;
    logic [3:0]  count;

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] mq[$];   // model contents, head at index 0

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid_1(in_valid_1), .in_valid_2(in_valid_2),
        .in_pc(in_pc), .in_inst_1(in_inst_1), .in_inst_2(in_inst_2),
        .in_stall(in_stall),
        .out_valid_1(out_valid_1), .out_valid_2(out_valid_2),
        .out_pc_1(out_pc_1), .out_inst_1(out_inst_1),
        .out_pc_2(out_pc_2), .out_inst_2(out_inst_2),
        .out_ready_1(out_ready_1), .out_ready_2(out_ready_2),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare DUT outputs against the model (called once per cycle).
    task automatic check_model();
        int sz = mq.size();
        chk("m_count",  32'(count), 32'(sz));
        chk("m_valid1", 32'(out_valid_1), 32'(sz >= 1));
        chk("m_valid2", 32'(out_valid_2), 32'(sz >= 2));
        chk("m_stall",  32'(in_stall), 32'(sz > DEPTH - 2));
        if (sz >= 1) begin
            chk("m_pc1",   out_pc_1,   mq[0][63:32]);
            chk("m_inst1", out_inst_1, mq[0][31:0]);
        end
        if (sz >= 2) begin
            chk("m_pc2",   out_pc_2,   mq[1][63:32]);
            chk("m_inst2", out_inst_2, mq[1][31:0]);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the queue rules, then
    // check at the following negedge.
    task automatic cycle(input logic rst_n, input logic fl,
                         input logic v1, input logic v2, input logic [31:0] pc,
                         input logic [31:0] i1, input logic [31:0] i2,
                         input logic r1, input logic r2);
        int sz, npush, npop;
        resetn = rst_n; flush = fl;
        in_valid_1 = v1; in_valid_2 = v2; in_pc = pc;
        in_inst_1 = i1; in_inst_2 = i2;
        out_ready_1 = r1; out_ready_2 = r2;
        sz = mq.size();
        if (!rst_n || fl) begin
            mq.delete();
        end else begin
            npop  = !(r1 && sz >= 1) ? 0 : ((r2 && sz >= 2) ? 2 : 1);
            npush = (!v1 || sz > DEPTH - 2) ? 0 : (v2 ? 2 : 1);
            repeat (npop) void'(mq.pop_front());
            if (npush >= 1) mq.push_back({pc, i1});
            if (npush == 2) mq.push_back({pc + 32'd4, i2});
        end
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic idle();
        cycle(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
    endtask
    task automatic push2(input logic [31:0] pc);
        cycle(1, 0, 1, 1, pc, pc ^ 32'hA5A5_0000, pc ^ 32'h5A5A_0000, 0, 0);
    endtask
    task automatic push1(input logic [31:0] pc);
        cycle(1, 0, 1, 0, pc, pc ^ 32'hA5A5_0000, 32'h0, 0, 0);
    endtask
    task automatic pop(input logic two);
        cycle(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, two);
    endtask

    task automatic dual_push_pop_scenario(input string tag);
        cycle(1, 0, 1, 1, 32'h1000, 32'hAAAA_0001, 32'hBBBB_0002, 0, 0);
        chk({tag, "_count2"}, 32'(count), 32'd2);
        chk({tag, "_pc1"},   out_pc_1,   32'h1000);
        chk({tag, "_pc2"},   out_pc_2,   32'h1004);
        chk({tag, "_inst1"}, out_inst_1, 32'hAAAA_0001);
        chk({tag, "_inst2"}, out_inst_2, 32'hBBBB_0002);
        pop(1);
        chk({tag, "_count0"}, 32'(count), 32'd0);
    endtask

    initial begin
        resetn = 0; flush = 0; in_valid_1 = 0; in_valid_2 = 0;
        in_pc = '0; in_inst_1 = '0; in_inst_2 = '0;
        out_ready_1 = 0; out_ready_2 = 0;
        @(negedge clk);

        // Reset state
        cycle(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        cycle(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid1", 32'(out_valid_1), 32'd0);
        chk("rst_stall", 32'(in_stall), 32'd0);

        // Dual push then dual pop
        dual_push_pop_scenario("dual");

        // Fill
        push2(32'h100); push2(32'h200); push2(32'h300);
        chk("fill_count6", 32'(count), 32'd6);
        chk("fill_stall0", 32'(in_stall), 32'd0);
        push2(32'h400);
        chk("fill_count8", 32'(count), 32'd8);
        chk("fill_stall1", 32'(in_stall), 32'd1);
        push2(32'h500);
        chk("fill_drop", 32'(count), 32'd8);

        // Simultaneous push 2 / pop 1 at count 3
        cycle(1, 1, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        push2(32'h3000); push1(32'h3100);
        chk("sim_count3", 32'(count), 32'd3);
        cycle(1, 0, 1, 1, 32'h3200, 32'h11, 32'h22, 1, 0);
        chk("sim_count4", 32'(count), 32'd4);
        chk("sim_head", out_pc_1, 32'h3004);

        // Wrap-around: bring wptr=rptr=7 with an empty queue
        cycle(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        push2(32'h10); push2(32'h20); push2(32'h30); push1(32'h40);
        pop(1); pop(1); pop(1); pop(0);
        chk("wrap_empty", 32'(count), 32'd0);
        cycle(1, 0, 1, 1, 32'h2000, 32'hC0DE_0007, 32'hC0DE_0000, 0, 0);
        chk("wrap_pc1", out_pc_1, 32'h2000);
        chk("wrap_pc2", out_pc_2, 32'h2004);
        chk("wrap_inst2", out_inst_2, 32'hC0DE_0000);
        pop(0);
        chk("wrap_after_pop", out_pc_1, 32'h2004);

        // Flush with a push at count 5
        cycle(1, 1, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        push2(32'h600); push2(32'h700); push1(32'h800);
        chk("flush_count5", 32'(count), 32'd5);
        cycle(1, 1, 1, 0, 32'h900, 32'hDEAD_0009, 32'h0, 0, 0);
        chk("flush_count0", 32'(count), 32'd0);
        chk("flush_valid1", 32'(out_valid_1), 32'd0);
        idle();
        chk("flush_nopush", 32'(out_valid_1), 32'd0);

        // Reset mid-operation
        push2(32'hA00); push2(32'hB00);
        chk("mrst_count4", 32'(count), 32'd4);
        cycle(0, 0, 1, 1, 32'hC00, 32'h1, 32'h2, 1, 1);
        chk("mrst_count0", 32'(count), 32'd0);
        chk("mrst_valid1", 32'(out_valid_1), 32'd0);
        chk("mrst_stall", 32'(in_stall), 32'd0);
        dual_push_pop_scenario("mrst");

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic rn, fl;
            rn = ($urandom_range(0, 99) != 0);
            fl = ($urandom_range(0, 39) == 0);
            cycle(rn, fl,
                  ($urandom_range(0, 3) != 0), 1'($urandom),
                  $urandom, $urandom, $urandom,
                  ($urandom_range(0, 2) != 0), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
